// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the IF (instruction fetch) and MEM (load/store) stages.
// MEM has fixed priority. Each access runs issue/wait/response and ends in a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack,
  output logic              err
);

  localparam logic [7:0]  CntLast   = 8'(TIMEOUT - 1);
  localparam logic [31:0] AbortData = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic              owner_mem_q;
  logic [7:0]        cnt_q;
  logic              en_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       mem_rdata_q;
  logic              err_q;

  logic              mem_any;
  logic              done;
  logic              timed_out;
  logic [31:0]       done_data;

  // Byte-offset bits and bits above the word-address range are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0],
                              if_addr[31:ADDR_W+2], mem_addr[31:ADDR_W+2]};

  assign mem_any = mem_rd_req | mem_wr_req;

  always_comb begin
    done      = 1'b0;
    timed_out = 1'b0;
    done_data = we_q ? 32'h0 : sram_rdata;
    case (state_q)
      StIssue: done = sram_ack;
      StWait: begin
        // A late ack in the final wait cycle still wins over the abort.
        timed_out = !sram_ack && (cnt_q == CntLast);
        done      = sram_ack || timed_out;
        if (timed_out) done_data = AbortData;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_mem_q <= 1'b0;
      cnt_q       <= 8'd0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      en_q        <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if (timed_out) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (mem_any) begin
            owner_mem_q <= 1'b1;
            addr_q      <= mem_addr[ADDR_W+1:2];
            wdata_q     <= mem_wdata;
            we_q        <= mem_wr_req;
            en_q        <= 1'b1;
            cnt_q       <= 8'd0;
            state_q     <= StIssue;
            if (mem_rd_req && mem_wr_req) err_q <= 1'b1;
          end else if (if_req) begin
            owner_mem_q <= 1'b0;
            addr_q      <= if_addr[ADDR_W+1:2];
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            en_q        <= 1'b1;
            cnt_q       <= 8'd0;
            state_q     <= StIssue;
          end
        end
        StIssue, StWait: begin
          if (done) begin
            state_q <= StResp;
            if (owner_mem_q) begin
              mem_ready_q <= 1'b1;
              mem_rdata_q <= done_data;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= done_data;
            end
          end else begin
            state_q <= StWait;
            if (state_q == StWait) cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sram_en    = en_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_ready   = if_ready_q;
  assign if_rdata   = if_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a word-memory responder plus a reference model that
// predicts latency, returned data and the sticky error flag from the access rules.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = 32'h0;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          mem_rd_req = 1'b0;
  logic          mem_wr_req = 1'b0;
  logic [31:0]   mem_addr = 32'h0;
  logic [31:0]   mem_wdata = 32'h0;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'h0;
  logic          sram_ack = 1'b0;
  logic          err;

  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_err = 1'b0;

  logic [31:0] ref_mem  [65536];
  logic [31:0] sram_mem [65536];

  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ack   (sram_ack),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One access from request (driven in an IDLE cycle) to the IDLE cycle after ready.
  // delay = wait cycles before ack (0: ack in ISSUE); delay > TO means no ack.
  task automatic run_txn(input bit use_if, input bit rd, input bit wr, input bit also_if,
                         input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                         input string name);
    bit            timeout   = (delay > int'(TO));
    int            exp_lat   = 2 + (timeout ? int'(TO) : delay);
    int            ack_c     = 1 + (timeout ? int'(TO) : delay);
    int unsigned   word      = (addr >> 2) % 65536;
    logic [AW-1:0] exp_word  = AW'(word);
    bit            exp_we    = !use_if && wr;
    logic [31:0]   exp_rd;
    int            got_lat   = -1;
    logic [31:0]   got_data  = 32'h0;
    int            en_cnt    = 0;
    int            hold_bad  = 0;
    bit            other_seen = 1'b0;
    logic          post_ready;

    exp_rd = timeout ? 32'hDEAD_BEEF : (exp_we ? 32'h0 : ref_mem[word]);
    if (exp_we && !timeout) ref_mem[word] = wdata;
    if (timeout || (!use_if && rd && wr)) exp_err = 1'b1;

    if (use_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_rd_req = rd;
      mem_wr_req = wr;
      mem_addr   = addr;
      mem_wdata  = wdata;
      if (also_if) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
    end
    sram_ack   = 1'($urandom_range(0, 1));
    sram_rdata = $urandom;

    for (int c = 1; c <= exp_lat + 3; c++) begin
      @(posedge clk); #1;
      sram_ack = 1'b0;
      if (c == 1) begin
        if_addr   = $urandom;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
      if (sram_en) en_cnt++;
      if (c <= ack_c) begin
        if (sram_addr !== exp_word || sram_we !== exp_we || sram_en !== (c == 1) ||
            (exp_we && sram_wdata !== wdata)) hold_bad++;
      end
      if (!timeout && c == ack_c) begin
        sram_ack   = 1'b1;
        sram_rdata = sram_mem[sram_addr];
        if (sram_we) sram_mem[sram_addr] = sram_wdata;
      end
      if (use_if ? mem_ready : if_ready) other_seen = 1'b1;
      if (use_if ? if_ready : mem_ready) begin
        got_lat  = c;
        got_data = use_if ? if_rdata : mem_rdata;
        break;
      end
    end

    if (use_if) if_req = 1'b0;
    else begin
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
    end
    sram_ack = 1'b0;
    @(posedge clk); #1;
    post_ready = use_if ? if_ready : mem_ready;

    n_total++;
    if (got_lat !== exp_lat)
      $display("FAIL %s latency: got %0d want %0d", name, got_lat, exp_lat);
    else n_pass++;
    n_total++;
    if (got_data !== exp_rd)
      $display("FAIL %s rdata: got %h want %h", name, got_data, exp_rd);
    else n_pass++;
    n_total++;
    if (other_seen !== 1'b0)
      $display("FAIL %s non-owner ready: got %0b want 0", name, other_seen);
    else n_pass++;
    n_total++;
    if (en_cnt !== 1)
      $display("FAIL %s sram_en cycles: got %0d want 1", name, en_cnt);
    else n_pass++;
    n_total++;
    if (hold_bad !== 0)
      $display("FAIL %s command hold: got %0d bad cycles want 0", name, hold_bad);
    else n_pass++;
    n_total++;
    if (post_ready !== 1'b0)
      $display("FAIL %s ready pulse width: got ready=%0b after pulse want 0", name, post_ready);
    else n_pass++;
    n_total++;
    if (err !== exp_err)
      $display("FAIL %s err: got %0b want %0b", name, err, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [103:0] outs;
    rst    = 1'b0;
    if_req = 1'b1;
    mem_rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = {if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, err, 16'(sram_addr),
            sram_wdata[4:0]};
    n_total++;
    if (outs !== '0) $display("FAIL reset outputs: got %h want 0", outs);
    else n_pass++;
    n_total++;
    if (sram_wdata !== 32'h0) $display("FAIL reset sram_wdata: got %h want 0", sram_wdata);
    else n_pass++;
    if_req     = 1'b0;
    mem_rd_req = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_read();
    sram_mem[2] = 32'hE3A0_1005;
    ref_mem[2]  = 32'hE3A0_1005;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 0, "if_read");
  endtask

  task automatic test_priority();
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 0, "prio_mem");
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1, "prio_if");
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h1234_5678, 3, "store");
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 1, "store_readback");
  endtask

  task automatic test_conflict();
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0820, 32'hCAFE_0001, 1, "conflict");
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0820, 32'h0, 0, "conflict_readback");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    mem_rd_req = 1'b1;
    mem_addr   = 32'h0000_0C00;
    sram_ack   = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    n_total++;
    if ({if_ready, mem_ready, sram_en, sram_we, err} !== 5'b0 || sram_addr !== '0 ||
        if_rdata !== 32'h0 || mem_rdata !== 32'h0)
      $display("FAIL reset_mid outputs: got ready=%0b/%0b en=%0b err=%0b addr=%h want all 0",
               if_ready, mem_ready, sram_en, err, sram_addr);
    else n_pass++;
    exp_err    = 1'b0;
    mem_rd_req = 1'b0;
    sram_ack   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      sram_ack = 1'b0;
      if (if_ready || mem_ready || sram_en) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL reset_mid late ack: got %0d active cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL reset_mid err: got %0b want 0", err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, TO + 2, "timeout");
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, TO, "ack_last_wait");
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, $urandom, 32'h0, TO + 1, "if_timeout");
  endtask

  task automatic test_random();
    bit prev_also = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit use_if = prev_also ? 1'b1 : 1'($urandom_range(0, 1));
      int kind   = $urandom_range(0, 9);
      bit rd     = !use_if && (kind <= 4 || kind == 9);
      bit wr     = !use_if && kind >= 5;
      bit also   = !use_if && ($urandom_range(0, 3) == 0);
      // Random addresses are confined to a small window so reads often hit earlier writes.
      logic [31:0] a = {$urandom_range(0, 3) == 0 ? 14'($urandom) : 14'h0, 18'($urandom_range(0, 63) << 2)}
                       | 32'($urandom_range(0, 3));
      run_txn(use_if, rd, wr, also, a, $urandom, $urandom_range(0, TO + 2), "random");
      prev_also = also;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i]  = 32'(i) * 32'h0100_0193 ^ 32'hA5A5_0000;
      sram_mem[i] = 32'(i) * 32'h0100_0193 ^ 32'hA5A5_0000;
    end
    test_reset();
    test_if_read();
    test_priority();
    test_store();
    test_conflict();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
